// File: rtl/nrf24_pkg.sv
// Shared constants for the nRF24L01 SPI responder: register map, opcodes,
// reset table and FSM state encodings.
package nrf24_pkg;

    localparam logic [4:0] ADDR_CONFIG     = 5'h00;
    localparam logic [4:0] ADDR_EN_AA      = 5'h01;
    localparam logic [4:0] ADDR_EN_RXADDR  = 5'h02;
    localparam logic [4:0] ADDR_SETUP_AW   = 5'h03;
    localparam logic [4:0] ADDR_SETUP_RETR = 5'h04;
    localparam logic [4:0] ADDR_RF_CH      = 5'h05;
    localparam logic [4:0] ADDR_RF_SETUP   = 5'h06;
    localparam logic [4:0] ADDR_STATUS     = 5'h07;

    localparam logic [2:0] OP_R_REGISTER = 3'b000;
    localparam logic [2:0] OP_W_REGISTER = 3'b001;
    localparam logic [7:0] OP_NOP        = 8'hFF;

    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_CMD       = 2'd2;
    localparam logic [1:0] ST_DATA      = 2'd3;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2
    } cmd_kind_t;

    function automatic logic [7:0] reset_value(input logic [4:0] addr);
        case (addr)
            ADDR_CONFIG:     return 8'h08;
            ADDR_EN_AA:      return 8'h3F;
            ADDR_EN_RXADDR:  return 8'h03;
            ADDR_SETUP_AW:   return 8'h03;
            ADDR_SETUP_RETR: return 8'h03;
            ADDR_RF_CH:      return 8'h02;
            ADDR_RF_SETUP:   return 8'h0E;
            ADDR_STATUS:     return 8'h0E;
            default:         return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/nrf24_spi_responder_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall
// strobes derived from the last two synchronized samples.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;

    // Chain resets low so a CSN held low through reset never looks like a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/nrf24_spi_responder.sv
// SPI mode-0 slave emulating the nRF24L01 register interface, used to
// loop-test the SPI master without a radio attached.
module nrf24_spi_responder
    import nrf24_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       csn,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [2:0] irq_set,
    output logic       irq_n,
    output logic       wr_stb,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [1:0] dbg_state
);
    logic csn_lvl, csn_rise, csn_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_csn  (.clk(clk), .rst(rst), .din(csn),
        .level(csn_lvl), .rise(csn_rise), .fall(csn_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck  (.clk(clk), .rst(rst), .din(sck),
        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (.clk(clk), .rst(rst), .din(mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

    logic unused_edges;
    assign unused_edges = sck_lvl | mosi_rise | mosi_fall;

    logic [1:0]  state;
    logic [7:0]  regs [32];
    logic [7:0]  tx_shift, rx_shift;
    logic [2:0]  bit_cnt;
    logic [4:0]  cmd_addr;
    cmd_kind_t   cmd_kind;
    logic        written;
    logic [7:0]  byte_in;
    logic        commit;
    logic [2:0]  status_clr;

    function automatic logic [7:0] reg_read(input logic [4:0] a);
        return (int'(a) < NUM_REGS) ? regs[a] : 8'h00;
    endfunction

    assign byte_in = {rx_shift[6:0], mosi_lvl};
    assign commit  = (state == ST_DATA) && sck_rise && !csn_rise && (bit_cnt == 3'd7) &&
                     (cmd_kind == CMD_WRITE) && !written && (int'(cmd_addr) < NUM_REGS);
    assign status_clr = (commit && cmd_addr == ADDR_STATUS) ? byte_in[6:4] : 3'b000;

    assign miso_oe   = ((state == ST_CMD) || (state == ST_DATA)) && !csn_lvl;
    assign dbg_state = state;

    // STATUS[6:4] is W1C with irq_set winning; STATUS[3:0] and bit 7 never take SPI data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= reset_value(i[4:0]);
        end else begin
            if (commit && cmd_addr != ADDR_STATUS) regs[cmd_addr] <= byte_in;
            regs[ADDR_STATUS][6:4] <= (regs[ADDR_STATUS][6:4] & ~status_clr) | irq_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_stb  <= 1'b0;
            wr_addr <= 5'd0;
            wr_data <= 8'd0;
            irq_n   <= 1'b1;
        end else begin
            wr_stb <= commit;
            if (commit) begin
                wr_addr <= cmd_addr;
                wr_data <= byte_in;
            end
            irq_n <= ~|(regs[ADDR_STATUS][6:4] & ~regs[ADDR_CONFIG][6:4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_WAIT_IDLE;
            miso     <= 1'b0;
            tx_shift <= 8'd0;
            rx_shift <= 8'd0;
            bit_cnt  <= 3'd0;
            cmd_addr <= 5'd0;
            cmd_kind <= CMD_NONE;
            written  <= 1'b0;
        end else if (csn_rise) begin
            state <= ST_IDLE;
            miso  <= 1'b0;
        end else begin
            case (state)
                ST_WAIT_IDLE: if (csn_lvl) state <= ST_IDLE;
                ST_IDLE: begin
                    if (csn_fall) begin
                        state    <= ST_CMD;
                        tx_shift <= regs[ADDR_STATUS];
                        miso     <= regs[ADDR_STATUS][7];
                        bit_cnt  <= 3'd0;
                        written  <= 1'b0;
                    end
                end
                default: begin
                    if (sck_rise) begin
                        rx_shift <= byte_in;
                        bit_cnt  <= bit_cnt + 3'd1;
                        // Byte boundary: preload the next outgoing byte.
                        if (bit_cnt == 3'd7) begin
                            if (state == ST_CMD) begin
                                state    <= ST_DATA;
                                cmd_addr <= byte_in[4:0];
                                if (byte_in[7:5] == OP_R_REGISTER) begin
                                    cmd_kind <= CMD_READ;
                                    tx_shift <= reg_read(byte_in[4:0]);
                                end else begin
                                    cmd_kind <= (byte_in[7:5] == OP_W_REGISTER) ? CMD_WRITE
                                                                                : CMD_NONE;
                                    tx_shift <= 8'h00;
                                end
                            end else begin
                                tx_shift <= (cmd_kind == CMD_READ) ? reg_read(cmd_addr) : 8'h00;
                                if (cmd_kind == CMD_WRITE) written <= 1'b1;
                            end
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt == 3'd0) begin
                            miso <= tx_shift[7];
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            miso     <= tx_shift[6];
                        end
                    end
                end
            endcase
        end
    end

endmodule
